// File: rtl/rice_bus_arbiter_if.sv
// rice_bus_if: request/response bus shared by core masters and memory ports.
// master issues requests and accepts responses; slave is the opposite side.
interface rice_bus_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8
);
  logic                     request_valid;
  logic                     request_ready;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [STROBE_WIDTH-1:0]  strobe;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     response_valid;
  logic                     response_ready;
  logic [DATA_WIDTH-1:0]    read_data;
  logic                     error;

  modport master (
    output request_valid, address, strobe, write_data, response_ready,
    input  request_ready, response_valid, read_data, error
  );

  modport slave (
    input  request_valid, address, strobe, write_data, response_ready,
    output request_ready, response_valid, read_data, error
  );
endinterface

// File: rtl/rice_bus_arbiter.sv
// rice_bus_arbiter: round-robin N:1 bus arbiter with in-order response routing.
// Define RICE_BUS_ARBITER_STATUS_EN to add o_outstanding / o_last_grant.
module rice_bus_arbiter #(
  parameter int REQUESTERS      = 2,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int STROBE_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int ID_WIDTH  = $clog2(REQUESTERS),
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1),
  localparam int PTR_WIDTH =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  rice_bus_if.slave   slave_if [REQUESTERS],
  rice_bus_if.master  master_if
`ifdef RICE_BUS_ARBITER_STATUS_EN
  ,
  output logic [CNT_WIDTH-1:0] o_outstanding,
  output logic [ID_WIDTH-1:0]  o_last_grant
`endif
);

  logic [ID_WIDTH-1:0]      r_rr_ptr;
  logic                     r_lock;
  logic [ID_WIDTH-1:0]      r_lock_id;
  logic [ID_WIDTH-1:0]      r_fifo [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0]     r_wr_ptr;
  logic [PTR_WIDTH-1:0]     r_rd_ptr;
  logic [CNT_WIDTH-1:0]     r_count;

  logic [REQUESTERS-1:0]    w_req_valid;
  logic [REQUESTERS-1:0]    w_rsp_ready;
  logic [ADDRESS_WIDTH-1:0] w_addr  [REQUESTERS];
  logic [STROBE_WIDTH-1:0]  w_strb  [REQUESTERS];
  logic [DATA_WIDTH-1:0]    w_wdata [REQUESTERS];

  logic                     w_has_grant;
  logic [ID_WIDTH-1:0]      w_grant;
  logic                     w_gvalid;
  logic                     w_not_full;
  logic                     w_accept;
  logic                     w_stall;
  logic                     w_nonempty;
  logic [ID_WIDTH-1:0]      w_head;
  logic                     w_mrsp_ready;
  logic                     w_pop;

  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_slave
    assign w_req_valid[gi] = slave_if[gi].request_valid;
    assign w_rsp_ready[gi] = slave_if[gi].response_ready;
    assign w_addr[gi]      = slave_if[gi].address;
    assign w_strb[gi]      = slave_if[gi].strobe;
    assign w_wdata[gi]     = slave_if[gi].write_data;

    assign slave_if[gi].request_ready =
      w_has_grant && (w_grant == ID_WIDTH'(gi)) &&
      master_if.request_ready && w_not_full;
    assign slave_if[gi].response_valid =
      w_nonempty && (w_head == ID_WIDTH'(gi)) &&
      master_if.response_valid;
    assign slave_if[gi].read_data = master_if.read_data;
    assign slave_if[gi].error     = master_if.error;
  end

  // Scan high-to-low so the nearest requester after rr_ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    w_has_grant = 1'b0;
    w_grant     = '0;
    if (r_lock) begin
      w_has_grant = 1'b1;
      w_grant     = r_lock_id;
    end else begin
      for (int k = REQUESTERS - 1; k >= 0; k--) begin
        idx = (int'(r_rr_ptr) + k) % REQUESTERS;
        if (w_req_valid[idx]) begin
          w_has_grant = 1'b1;
          w_grant     = ID_WIDTH'(idx);
        end
      end
    end
    if (i_rst) begin
      w_has_grant = 1'b0;
    end
  end

  // Full is taken from the registered count only; a pop frees a slot next cycle.
  assign w_not_full = (r_count != CNT_WIDTH'(MAX_OUTSTANDING));
  assign w_gvalid   = w_has_grant && w_req_valid[w_grant];
  assign w_accept   = w_gvalid && w_not_full && master_if.request_ready;
  assign w_stall    = w_gvalid && !w_accept;

  assign master_if.request_valid = w_gvalid && w_not_full;

  always_comb begin
    master_if.address    = '0;
    master_if.strobe     = '0;
    master_if.write_data = '0;
    if (w_has_grant) begin
      master_if.address    = w_addr[w_grant];
      master_if.strobe     = w_strb[w_grant];
      master_if.write_data = w_wdata[w_grant];
    end
  end

  assign w_nonempty   = (r_count != '0) && !i_rst;
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_mrsp_ready = w_nonempty && w_rsp_ready[w_head];
  assign w_pop        = w_mrsp_ready && master_if.response_valid;

  assign master_if.response_ready = w_mrsp_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= (w_grant == ID_WIDTH'(REQUESTERS - 1)) ?
                    '0 : w_grant + 1'b1;
        r_lock   <= 1'b0;
        r_wr_ptr <= (r_wr_ptr == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ?
                    '0 : r_wr_ptr + 1'b1;
      end else if (w_stall) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_grant;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ?
                    '0 : r_rd_ptr + 1'b1;
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept && !i_rst) begin
      r_fifo[r_wr_ptr] <= w_grant;
    end
  end

`ifdef RICE_BUS_ARBITER_STATUS_EN
  logic [ID_WIDTH-1:0] r_last_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
    end
  end

  assign o_outstanding = r_count;
  assign o_last_grant  = r_last_grant;
`endif

endmodule
